// File: rtl/fir_output_requantizer.sv
// ---------------------------------------------------------------------------
// fir_output_requantizer
//   Takes the wide signed FIR accumulator word and brings it back to sample
//   precision. It applies an arithmetic right shift with round-half-up,
//   saturates the result to OUT_WIDTH and buffers it in a small FIFO. The
//   result is presented on a valid/ready interface. The FIR upstream cannot
//   be stalled, so the block flags lost samples and counts saturations.
//
// Ports:
//   clk             in   single clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   acc_in          in   signed accumulator word (ACC_WIDTH)
//   acc_in_valid    in   one-cycle qualifier for acc_in
//   out_data        out  head-of-FIFO sample, 0 when FIFO empty
//   out_valid       out  FIFO non-empty
//   out_ready       in   consumer accepts out_data on out_valid && out_ready
//   fifo_level      out  current FIFO occupancy
//   sat_count       out  saturated samples since reset/clear, sticks at max
//   overflow_sticky out  a sample was dropped because the FIFO was full
//   clear           in   synchronous clear of sat_count / overflow_sticky
// ---------------------------------------------------------------------------
module fir_output_requantizer #(
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ACC_WIDTH-1:0]               acc_in,
    input  logic                               acc_in_valid,
    output logic [OUT_WIDTH-1:0]               out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic [CNT_WIDTH-1:0]               sat_count,
    output logic                               overflow_sticky,
    input  logic                               clear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int QW    = ACC_WIDTH + 1;

    // Half an output LSB; zero when no shift is applied.
    localparam logic signed [QW-1:0] ROUND_C =
        (SHIFT == 0) ? {QW{1'b0}} : ({{(QW-1){1'b0}}, 1'b1} << ((SHIFT > 0) ? (SHIFT - 1) : 0));
    localparam logic signed [QW-1:0] Q_MAX = QW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [QW-1:0] Q_MIN = QW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    // True when the shifted value lies outside the output range.
    function automatic logic is_saturating(input logic signed [QW-1:0] q);
        return (q > Q_MAX) || (q < Q_MIN);
    endfunction

    // Clamp the shifted value to the signed output range.
    function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [QW-1:0] q);
        logic [OUT_WIDTH-1:0] r;
        if (q > Q_MAX) begin
            r = Q_MAX[OUT_WIDTH-1:0];
        end else if (q < Q_MIN) begin
            r = Q_MIN[OUT_WIDTH-1:0];
        end else begin
            r = q[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    logic signed [QW-1:0]     sum_s;
    logic signed [QW-1:0]     q_s;
    logic                     s1_valid_r;
    logic signed [QW-1:0]     s1_q_r;
    logic [OUT_WIDTH-1:0]     sat_val_s;
    logic                     sat_event_s;
    logic                     full_s;
    logic                     rd_s;
    logic                     wr_s;
    logic                     drop_s;
    logic [OUT_WIDTH-1:0]     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [LVL_W-1:0]         level_r;
    logic [CNT_WIDTH-1:0]     sat_count_r;
    logic                     overflow_r;

    // Stage-1 rounding add; one extra bit keeps the add from wrapping.
    always_comb begin
        sum_s = $signed({acc_in[ACC_WIDTH-1], acc_in}) + ROUND_C;
        q_s   = sum_s >>> SHIFT;
    end

    // Stage-1 register: shifted value and its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_q_r     <= '0;
        end else begin
            s1_valid_r <= acc_in_valid;
            if (acc_in_valid) begin
                s1_q_r <= q_s;
            end
        end
    end

    // Stage-2 saturation and FIFO handshake decode. A full FIFO still
    // accepts the write when the head is being read on the same edge.
    always_comb begin
        sat_val_s   = saturate(s1_q_r);
        sat_event_s = s1_valid_r && is_saturating(s1_q_r);
        full_s      = (level_r == LVL_W'(FIFO_DEPTH));
        rd_s        = (level_r != {LVL_W{1'b0}}) && out_ready;
        wr_s        = s1_valid_r && (!full_s || rd_s);
        drop_s      = s1_valid_r && full_s && !rd_s;
    end

    // FIFO storage; stale contents are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= sat_val_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_s, rd_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Status: clear wins over same-edge saturation / drop events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_r <= '0;
            overflow_r  <= 1'b0;
        end else if (clear) begin
            sat_count_r <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (sat_event_s && (sat_count_r != {CNT_WIDTH{1'b1}})) begin
                sat_count_r <= sat_count_r + CNT_WIDTH'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign out_valid       = (level_r != {LVL_W{1'b0}});
    assign out_data        = out_valid ? mem_r[rd_ptr_r] : {OUT_WIDTH{1'b0}};
    assign fifo_level      = level_r;
    assign sat_count       = sat_count_r;
    assign overflow_sticky = overflow_r;

endmodule

// File: tb/tb_fir_output_requantizer.sv
// ---------------------------------------------------------------------------
// tb_fir_output_requantizer
//   Scoreboard bench. The stimulus side pushes the exact rounded value of
//   every issued sample into a pending queue. A negedge monitor keeps a
//   queue-level model of the FIFO, drop and saturation rules. It compares
//   every DUT output against that model and pops the expected head on each
//   accepted handshake.
// ---------------------------------------------------------------------------
module tb_fir_output_requantizer;

    localparam int ACC_WIDTH  = 40;
    localparam int OUT_WIDTH  = 16;
    localparam int SHIFT      = 15;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_WIDTH  = 16;
    localparam longint OMAX   = (64'sd1 <<< (OUT_WIDTH - 1)) - 1;
    localparam longint OMIN   = -(64'sd1 <<< (OUT_WIDTH - 1));
    localparam longint CMAX   = (64'sd1 <<< CNT_WIDTH) - 1;

    logic                          clk;
    logic                          rst_n;
    logic [ACC_WIDTH-1:0]          acc_in;
    logic                          acc_in_valid;
    logic [OUT_WIDTH-1:0]          out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic [CNT_WIDTH-1:0]          sat_count;
    logic                          overflow_sticky;
    logic                          clear;

    int tests;
    int fails;

    // Model state
    longint pend_q[$];
    longint fifo_m[$];
    bit     s1_valid_m;
    longint s1_q_m;
    longint sat_m;
    bit     ovf_m;

    fir_output_requantizer #(
        .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .acc_in_valid(acc_in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .sat_count(sat_count),
        .overflow_sticky(overflow_sticky), .clear(clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // floor((a + 2^(SHIFT-1)) / 2^SHIFT) on the exact signed value
    function automatic longint ref_q(input logic [ACC_WIDTH-1:0] d);
        longint a;
        a = longint'($signed(d));
        if (SHIFT == 0) return a;
        return (a + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    endfunction

    // One cycle of stimulus, driven just after the rising edge
    task automatic cyc(input bit v, input logic [ACC_WIDTH-1:0] d, input bit r, input bit c);
        @(posedge clk);
        #1;
        acc_in_valid = v;
        acc_in       = d;
        out_ready    = r;
        clear        = c;
        if (v) pend_q.push_back(ref_q(d));
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, r, 1'b0);
    endtask

    task automatic model_reset();
        pend_q.delete();
        fifo_m.delete();
        s1_valid_m = 1'b0;
        s1_q_m     = 0;
        sat_m      = 0;
        ovf_m      = 1'b0;
    endtask

    // Monitor: compare state, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            longint v;
            bit     sat_ev;
            bit     drop_ev;
            check("out_valid", longint'(out_valid), longint'(fifo_m.size() != 0));
            check("fifo_level", longint'(fifo_level), longint'(fifo_m.size()));
            check("sat_count", longint'(sat_count), sat_m);
            check("overflow_sticky", longint'(overflow_sticky), longint'(ovf_m));
            if (fifo_m.size() != 0)
                check("out_data", longint'($signed(out_data)), fifo_m[0]);
            else
                check("out_data_empty", longint'(out_data), 0);

            sat_ev  = 1'b0;
            drop_ev = 1'b0;
            if (fifo_m.size() != 0 && out_ready) void'(fifo_m.pop_front());
            if (s1_valid_m) begin
                v = s1_q_m;
                if (v > OMAX) begin v = OMAX; sat_ev = 1'b1; end
                else if (v < OMIN) begin v = OMIN; sat_ev = 1'b1; end
                if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(v);
                else drop_ev = 1'b1;
            end
            if (clear) begin
                sat_m = 0;
                ovf_m = 1'b0;
            end else begin
                if (sat_ev && sat_m < CMAX) sat_m = sat_m + 1;
                if (drop_ev) ovf_m = 1'b1;
            end
            if (pend_q.size() != 0) begin
                s1_valid_m = 1'b1;
                s1_q_m     = pend_q.pop_front();
            end else begin
                s1_valid_m = 1'b0;
            end
        end
    end

    initial begin
        logic [ACC_WIDTH-1:0] d;
        tests = 0;
        fails = 0;
        model_reset();
        rst_n = 1'b0;
        acc_in = '0;
        acc_in_valid = 1'b0;
        out_ready = 1'b0;
        clear = 1'b0;
        #2;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_fifo_level", longint'(fifo_level), 0);
        check("rst_sat_count", longint'(sat_count), 0);
        check("rst_overflow", longint'(overflow_sticky), 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single sample, latency
        cyc(1'b1, 40'd536870912, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Rounding boundaries
        cyc(1'b1, 40'sd16384, 1'b1, 1'b0);
        cyc(1'b1, -40'sd16384, 1'b1, 1'b0);
        cyc(1'b1, -40'sd16385, 1'b1, 1'b0);
        cyc(1'b1, 40'sd49151, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Saturation both ways, then clear
        cyc(1'b1, 40'h7F_FFFF_FFFF, 1'b1, 1'b0);
        cyc(1'b1, 40'h80_0000_0000, 1'b1, 1'b0);
        idle(4, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Overflow: 9 samples into a stalled FIFO, then drain
        for (int i = 1; i <= 9; i++) cyc(1'b1, 40'(i) << SHIFT, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(12, 1'b1);

        // Full FIFO with read on the 9th write edge
        cyc(1'b0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);
        for (int i = 1; i <= 9; i++) cyc(1'b1, 40'(i + 20) << SHIFT, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        idle(12, 1'b1);

        // Reset with 3 in FIFO and 1 in flight
        for (int i = 1; i <= 4; i++) cyc(1'b1, 40'(i + 40) << SHIFT, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_fifo_level", longint'(fifo_level), 0);
        idle(2, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(10, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0)
                d = {$urandom(), $urandom()};
            else
                d = 40'($signed(25'($urandom())));
            cyc(($urandom_range(3) != 0), d, ($urandom_range(2) != 0),
                ($urandom_range(49) == 0));
        end
        idle(20, 1'b1);
        check("final_out_valid", longint'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_output_requantizer.md
# fir_output_requantizer

Downstream stage of the parallel FIR filter. It takes the filter's wide signed accumulator output (`data_out`/`data_out_valid`, 40 bits) and arithmetic-shifts it back to sample precision with round-half-up. It then saturates the result to `OUT_WIDTH`, buffers it in a small FIFO, and presents it on a valid/ready interface to the consumer. The FIR cannot be back-pressured, so the block buffers bursts and flags any sample loss and any saturation.

## Interface
- `ACC_WIDTH`, 40, width of the signed input accumulator word
- `OUT_WIDTH`, 16, width of the signed output sample
- `SHIFT`, 15, right-shift amount (Q15 coefficients); valid range 0..ACC_WIDTH-OUT_WIDTH
- `FIFO_DEPTH`, 8, number of FIFO entries; power of two, ≥2
- `CNT_WIDTH`, 16, width of the saturation counter

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `acc_in`  in  ACC_WIDTH  signed FIR output (connects to FIR `data_out`)
- `acc_in_valid`  in  1  one-cycle qualifier; no ready returned upstream
- `out_data`  out  OUT_WIDTH  signed head-of-FIFO sample; 0 when FIFO empty
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready` at an edge
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `sat_count`  out  CNT_WIDTH  samples saturated since reset/clear; sticks at all-ones
- `overflow_sticky`  out  1  set when a sample is dropped because the FIFO is full
- `clear`  in  1  synchronous clear of `sat_count` and `overflow_sticky`

## Operation
- Stage 1, registered on the edge where `acc_in_valid`=1:
  - Compute `sum = acc_in + 2^(SHIFT-1)` in ACC_WIDTH+1 signed bits, so the add never wraps.
  - When SHIFT=0, add nothing.
  - Store `q = sum >>> SHIFT` (arithmetic shift) and a stage-1 valid bit.
- Stage 2, the edge after stage 1, when the stage-1 valid bit is set:
  - Saturate `q`: q > 2^(OUT_WIDTH-1)-1 gives 2^(OUT_WIDTH-1)-1; q < -2^(OUT_WIDTH-1) gives -2^(OUT_WIDTH-1); otherwise take the low OUT_WIDTH bits.
  - If saturation occurred, `sat_count` increments, holding at all-ones.
  - Write the result into the FIFO.
- FIFO: circular register array with read/write pointers and an occupancy count (`fifo_level`).
  - `out_valid` = (level≠0).
  - `out_data` = mem[rd_ptr] when non-empty, 0 when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Full FIFO on a stage-2 write:
  - If a read happens on the same edge, both the read and the write occur and the level is unchanged.
  - Otherwise the new sample is dropped, `overflow_sticky` is set, and FIFO contents, pointers and level are unchanged.
  - A dropped sample still counts toward `sat_count` if it saturated.
- Empty FIFO with a write on the same edge: no bypass; `out_valid` rises after that edge.
- Read and write on the same edge while non-full and non-empty: level unchanged.
- `clear` has priority over same-edge increment/set events. Those events are discarded, leaving `sat_count`=0 and `overflow_sticky`=0.
- `clear` does not affect the datapath or the FIFO.
- `out_ready` while `out_valid`=0 is ignored.

## Timing
- Reset (async assert, sync-safe deassert by design):
  - `out_valid`=0, `out_data`=0, `fifo_level`=0, `sat_count`=0, `overflow_sticky`=0.
  - Stage valid bits=0; pointers=0.
- Latency: `acc_in_valid` sampled at edge E0 → FIFO write at E1 → `out_valid`=1 just after E1 (if the FIFO was empty).
- Throughput: one sample per clock in. Sustained 1/clk out when `out_ready` is held high.
- Back-to-back valids on consecutive edges are each processed independently; the pipeline never stalls.
- Reset mid-operation: in-flight stage-1/2 samples and FIFO contents are discarded. Outputs reach reset values asynchronously, without waiting for a clock edge.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset, then `acc_in`=536870912 (0x4000<<15) valid 1 cycle, `out_ready`=1:
  - `out_valid` pulses 1 cycle, 2 edges after the input, with `out_data`=16384.
- Rounding with SHIFT=15, inputs 16384, -16384, -16385, 49151:
  - outputs in order 1, 0, -1, 1; `sat_count`=0.
- Saturation, inputs 40'sh7F_FFFF_FFFF then -2^39:
  - outputs 32767 then -32768; `sat_count`=2.
  - Then pulse `clear`: `sat_count`=0.
- Overflow, `out_ready`=0, 9 consecutive valid inputs 1..9 (pre-shifted by 2^15):
  - `fifo_level`=8, `overflow_sticky`=1.
  - Raising `out_ready` drains 1..8 in order, then `out_valid`=0.
- Full FIFO with simultaneous read and write (`out_ready`=1 on the edge where the 9th sample is written):
  - no drop, `overflow_sticky` stays 0, `fifo_level` stays 8.
- Reset mid-operation: assert `rst_n`=0 with 3 samples in the FIFO and 1 in flight:
  - `out_valid`=0 and `fifo_level`=0 immediately.
  - Nothing appears after `rst_n` is released.
